// File: rtl/player_respawn_controller.sv
// rtl/player_respawn_controller.sv - shared revive engine with round-robin grant, lives and blink gating
module player_respawn_controller #(
    parameter int REVIVE_CYCLES = 31_250_000,
    parameter int BLINK_HALF    = 1_562_500,
    parameter int LIVES         = 3
) (
    input  logic       clk6p25m,
    input  logic       reset,
    input  logic       p0_hit,
    input  logic       p1_hit,
    input  logic       p0_sprite,
    input  logic       p1_sprite,
    output logic       p0_visible,
    output logic       p1_visible,
    output logic [2:0] p0_lives,
    output logic [2:0] p1_lives,
    output logic [1:0] reviving,
    output logic       game_over
);

    localparam int WW = (REVIVE_CYCLES > 1) ? $clog2(REVIVE_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [1:0]      pending_q, pending_d;
    logic [1:0]      reviving_q, reviving_d;
    logic [1:0]      dead_q, dead_d;
    logic            game_over_q, game_over_d;
    logic [1:0][2:0] lives_q, lives_d;
    logic            last_served_q, last_served_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    logic       terminal;
    logic       grant_en;
    logic       winner;
    logic       finisher;
    logic [1:0] hit;

    assign hit      = {p1_hit, p0_hit};
    assign terminal = (state_q == ST_BUSY) && (win_cnt_q == WW'(REVIVE_CYCLES - 1));
    assign grant_en = (pending_q != 2'b00) && ((state_q == ST_IDLE) || terminal);
    // Tie goes to whoever was not served last; otherwise the lone requester.
    assign winner   = (pending_q == 2'b11) ? ~last_served_q : pending_q[1];
    assign finisher = reviving_q[1];

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        reviving_d    = reviving_q;
        dead_d        = dead_q;
        game_over_d   = game_over_q | (&dead_q);
        lives_d       = lives_q;
        last_served_d = last_served_q;
        win_cnt_d     = win_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (state_q == ST_BUSY) begin
            if (terminal) begin
                reviving_d    = 2'b00;
                state_d       = ST_IDLE;
                win_cnt_d     = '0;
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
                if (lives_q[finisher] == 3'd0) begin
                    dead_d[finisher] = 1'b1;
                end
            end else begin
                win_cnt_d = win_cnt_q + WW'(1);
                if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
        end

        // A terminal edge with a waiting requester hands over with no idle gap.
        if (grant_en) begin
            state_d            = ST_BUSY;
            pending_d[winner]  = 1'b0;
            reviving_d         = winner ? 2'b10 : 2'b01;
            win_cnt_d          = '0;
            blink_cnt_d        = '0;
            blink_phase_d      = 1'b0;
            last_served_d      = winner;
            if (lives_q[winner] != 3'd0) begin
                lives_d[winner] = lives_q[winner] - 3'd1;
            end
        end

        for (int n = 0; n < 2; n++) begin
            if (hit[n] && !pending_q[n] && !reviving_q[n] && !dead_q[n] && !game_over_q) begin
                pending_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk6p25m) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= 2'b00;
            reviving_q    <= 2'b00;
            dead_q        <= 2'b00;
            game_over_q   <= 1'b0;
            lives_q       <= {3'(LIVES), 3'(LIVES)};
            last_served_q <= 1'b1;
            win_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            reviving_q    <= reviving_d;
            dead_q        <= dead_d;
            game_over_q   <= game_over_d;
            lives_q       <= lives_d;
            last_served_q <= last_served_d;
            win_cnt_q     <= win_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    always_comb begin
        p0_visible = reviving_q[0] ? (p0_sprite & blink_phase_q) : (dead_q[0] ? 1'b0 : p0_sprite);
        p1_visible = reviving_q[1] ? (p1_sprite & blink_phase_q) : (dead_q[1] ? 1'b0 : p1_sprite);
    end

    assign p0_lives  = lives_q[0];
    assign p1_lives  = lives_q[1];
    assign reviving  = reviving_q;
    assign game_over = game_over_q;

endmodule
